// File: rtl/sdes_round_engine.sv
// Iterative S-DES engine: key schedule, then one Feistel round per clock.
// ROUNDS=2 gives standard S-DES. Decrypt reuses the same datapath with the subkeys in reverse order.
module sdes_round_engine #(
  parameter int ROUNDS = 2,
  parameter int KEY_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             decrypt,
  input  logic [KEY_W-1:0] key,
  input  logic [7:0]       q_in,
  output logic [7:0]       q_out,
  output logic             busy,
  output logic             done
);

  if (KEY_W != 10) begin : g_bad_key_w
    $error("sdes_round_engine: KEY_W must be 10");
  end
  if ((ROUNDS < 2) || (ROUNDS > 16) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
    $error("sdes_round_engine: ROUNDS must be even, 2..16");
  end

  localparam int CNT_W = $clog2(ROUNDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  // S-box tables, indexed by {row, col}, entry 0 in the LSBs
  localparam logic [31:0] S0_T = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                  2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
  localparam logic [31:0] S1_T = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                  2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

  typedef enum logic [1:0] {IDLE, KEYGEN, ROUND, DONE} state_t;

  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [4:0] rol5(input logic [4:0] h, input logic by_two);
    return by_two ? {h[2:0], h[4:3]} : {h[3:0], h[4]};
  endfunction

  function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] n);
    logic [3:0] idx;
    idx = {n[3], n[0], n[2], n[1]};
    return tbl[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] fk(input logic [3:0] r, input logic [7:0] sk);
    logic [7:0] x;
    logic [3:0] s;
    x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
    s = {sbox(S0_T, x[7:4]), sbox(S1_T, x[3:0])};
    return {s[2], s[0], s[1], s[3]};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       kreg;
  logic [7:0]       sk [ROUNDS];
  logic [3:0]       l, r;
  logic             dec;

  logic [9:0]       knext;
  logic [CNT_W-1:0] sk_idx;
  logic [3:0]       f_out;

  assign knext  = {rol5(kreg[9:5], cnt != '0), rol5(kreg[4:0], cnt != '0)};
  assign sk_idx = dec ? (LAST - cnt) : cnt;
  assign f_out  = fk(r, sk[sk_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      kreg  <= '0;
      l     <= '0;
      r     <= '0;
      dec   <= 1'b0;
      q_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < ROUNDS; i++) sk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            {l, r} <= ip(q_in);
            kreg   <= p10(key);
            dec    <= decrypt;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= KEYGEN;
          end
        end
        KEYGEN: begin
          kreg        <= knext;
          sk[cnt]     <= p8(knext);
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ROUND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ROUND: begin
          // Last round skips the swap; the result is latched as DONE is entered
          if (cnt == LAST) begin
            l     <= l ^ f_out;
            q_out <= ip_inv({l ^ f_out, r});
            done  <= 1'b1;
            state <= DONE;
          end else begin
            l   <= r;
            r   <= l ^ f_out;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_round_engine.sv
// Scoreboard bench for sdes_round_engine at ROUNDS = 2, 4 and 16.
// Stimulus pushes expected results; a monitor checks each done pulse.
module tb_sdes_round_engine;

  localparam logic [9:0] KAT_KEY = 10'b1010000010;
  localparam logic [7:0] KAT_PT  = 8'b10010111;
  localparam logic [7:0] KAT_CT  = 8'b00111000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s [3];
  logic       dec_s   [3];
  logic [9:0] key_s   [3];
  logic [7:0] qin_s   [3];
  logic [7:0] qout_s  [3];
  logic       busy_s  [3];
  logic       done_s  [3];

  always #5 clk = ~clk;

  sdes_round_engine #(.ROUNDS(2), .KEY_W(10)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .decrypt(dec_s[0]), .key(key_s[0]),
    .q_in(qin_s[0]), .q_out(qout_s[0]), .busy(busy_s[0]), .done(done_s[0]));
  sdes_round_engine #(.ROUNDS(4), .KEY_W(10)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .decrypt(dec_s[1]), .key(key_s[1]),
    .q_in(qin_s[1]), .q_out(qout_s[1]), .busy(busy_s[1]), .done(done_s[1]));
  sdes_round_engine #(.ROUNDS(16), .KEY_W(10)) u2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .decrypt(dec_s[2]), .key(key_s[2]),
    .q_in(qin_s[2]), .q_out(qout_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         inst;
    bit         use_q;
    logic [7:0] exp;
    int         acc;
  } exp_t;
  exp_t sb[$];

  function automatic int rounds_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 4 : 16);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_idle(input int i, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_s[i] && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy_s[i]) begin
      checks++;
      failures++;
      $display("FAIL timeout: inst %0d busy after %0d cycles, expected idle", i, bound);
    end
  endtask

  task automatic issue(input int i, input bit d, input logic [9:0] k, input logic [7:0] b,
                       input bit push, input bit use_q, input logic [7:0] exp, output int acc);
    exp_t e;
    wait_idle(i, 60);
    dec_s[i]   = d;
    key_s[i]   = k;
    qin_s[i]   = b;
    start_s[i] = 1'b1;
    @(posedge clk);
    #1;
    acc        = cyc;
    start_s[i] = 1'b0;
    if (push) begin
      e.inst = i; e.use_q = use_q; e.exp = exp; e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic run(input int i, input bit d, input logic [9:0] k, input logic [7:0] b,
                     input bit use_q, input logic [7:0] exp);
    int acc;
    issue(i, d, k, b, 1'b1, use_q, exp, acc);
    wait_idle(i, 2 * rounds_of(i) + 6);
  endtask

  // Monitor: every done pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_s[i]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: inst %0d pulsed done with no request outstanding", i);
          end else begin
            e = sb.pop_front();
            chk("done_inst", i, e.inst);
            if (e.use_q) chk("q_out", int'(qout_s[i]), int'(e.exp));
            chk("done_latency", cyc - e.acc, 2 * rounds_of(e.inst));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic [9:0] k;
    logic [7:0] b, ct;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; dec_s[i] = 1'b0; key_s[i] = '0; qin_s[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_q_out", int'(qout_s[i]), 0);
      chk("reset_busy", int'(busy_s[i]), 0);
      chk("reset_done", int'(done_s[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Subkey schedule probe during a known-answer encrypt
    issue(0, 1'b0, KAT_KEY, KAT_PT, 1'b1, 1'b1, KAT_CT, acc);
    repeat (2) @(posedge clk);
    #1;
    chk("subkey1", int'(u0.sk[0]), 8'hA4);
    chk("subkey2", int'(u0.sk[1]), 8'h43);
    wait_idle(0, 20);

    // Known answer with busy-width measurement
    issue(0, 1'b0, KAT_KEY, KAT_PT, 1'b1, 1'b1, KAT_CT, acc);
    n = 0;
    @(negedge clk);
    while (busy_s[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 5);

    run(0, 1'b1, KAT_KEY, KAT_CT, 1'b1, KAT_PT);

    // Inputs scrambled while busy must not disturb the result
    issue(0, 1'b0, KAT_KEY, KAT_PT, 1'b1, 1'b1, KAT_CT, acc);
    n = 0;
    while (n < 6) begin
      @(negedge clk);
      key_s[0] = 10'($urandom);
      qin_s[0] = 8'($urandom);
      dec_s[0] = 1'($urandom);
      n++;
    end
    wait_idle(0, 20);

    // start held high: one accept per six cycles
    wait_idle(0, 20);
    dec_s[0] = 1'b0; key_s[0] = KAT_KEY; qin_s[0] = KAT_PT; start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.inst = 0; e.use_q = 1'b1; e.exp = KAT_CT; e.acc = acc + 6 * j;
      sb.push_back(e);
    end
    repeat (12) @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    wait_idle(0, 20);

    // Reset during the second round cycle aborts with no done
    issue(0, 1'b0, KAT_KEY, KAT_PT, 1'b0, 1'b0, 8'h00, acc);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_q_out", int'(qout_s[0]), 0);
    chk("abort_busy", int'(busy_s[0]), 0);
    chk("abort_done", int'(done_s[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    run(0, 1'b0, KAT_KEY, KAT_PT, 1'b1, KAT_CT);

    // Round trips at ROUNDS=4 and ROUNDS=16
    for (int i = 1; i < 3; i++) begin
      for (int j = 0; j < 256; j++) begin
        k = 10'($urandom);
        b = 8'($urandom);
        run(i, 1'b0, k, b, 1'b0, 8'h00);
        ct = qout_s[i];
        run(i, 1'b1, k, ct, 1'b1, b);
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_done: %0d results outstanding, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
